// File: rtl/gol_pkg.sv
// Shared grid geometry, scan FSM states and row-slice helper for the LED
// matrix scanner.
package gol_pkg;

  localparam int unsigned GRID_W = 8;
  localparam int unsigned GRID_H = 8;
  localparam int unsigned CELLS  = GRID_W * GRID_H;

  typedef logic [CELLS-1:0] grid_t;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } scan_state_t;

  // Row 0 lives in the top byte; bit 7 of each byte is column 7.
  function automatic logic [GRID_W-1:0] row_of(grid_t g, int r);
    grid_t sh;
    sh = g << (GRID_W * r);
    return sh[CELLS-1 -: GRID_W];
  endfunction

endpackage

// File: rtl/gol_row_timer.sv
// Loadable down-counter; tc is high while the count sits at zero, so a load
// of N-1 gives an N-cycle phase ending on the cycle tc is seen.
module gol_row_timer #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          tc
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/gol_matrix_scan.sv
// Row-multiplexed 8x8 LED matrix driver with a one-deep pending grid slot;
// new generations are swapped in only at frame boundaries or while idle.
module gol_matrix_scan
  import gol_pkg::*;
#(
  parameter int unsigned ROW_TICKS   = 1000,
  parameter int unsigned BLANK_TICKS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [CELLS-1:0]    grid_in,
  input  logic                grid_valid,
  output logic                grid_ready,
  output logic [GRID_H-1:0]   row_sel,
  output logic [GRID_W-1:0]   col_data,
  output logic                frame_done
);

  localparam int unsigned MAX_TICKS = (ROW_TICKS > BLANK_TICKS) ? ROW_TICKS : BLANK_TICKS;
  localparam int unsigned TW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

  scan_state_t       state_q, state_d;
  logic [2:0]        row_q, row_d;
  grid_t             disp_q, disp_d;
  grid_t             pend_q, pend_d;
  logic              pend_full_q, pend_full_d;
  logic [GRID_H-1:0] row_sel_q, row_sel_d;
  logic [GRID_W-1:0] col_data_q, col_data_d;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_tc;
  logic          frame_end;
  logic          ready;
  logic          capture;
  logic          swap;

  gol_row_timer #(.CW(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  always_comb begin
    frame_end = (state_q == DRIVE) && (row_q == 3'd7) && tmr_tc;
    ready     = !pend_full_q || frame_end || (state_q == IDLE);
    capture   = grid_valid && ready;
    swap      = pend_full_q && (frame_end || (state_q == IDLE));

    state_d = state_q;
    row_d   = row_q;
    unique case (state_q)
      IDLE: begin
        state_d = BLANK;
        row_d   = 3'd0;
      end
      BLANK: if (tmr_tc) state_d = DRIVE;
      DRIVE: if (tmr_tc) begin
        state_d = BLANK;
        row_d   = row_q + 3'd1;
      end
      default: state_d = IDLE;
    endcase
    if (!enable) begin
      state_d = IDLE;
      row_d   = 3'd0;
    end

    // Idle keeps the timer primed so the first blank phase is full length.
    tmr_load = (state_q == IDLE) || tmr_tc;
    tmr_val  = (state_q == BLANK) ? TW'(ROW_TICKS - 1) : TW'(BLANK_TICKS - 1);

    disp_d      = swap ? pend_q : disp_q;
    pend_d      = pend_q;
    pend_full_d = swap ? 1'b0 : pend_full_q;
    if (capture) begin
      pend_d      = grid_in;
      pend_full_d = 1'b1;
    end

    row_sel_d  = '0;
    col_data_d = '0;
    if (state_d == DRIVE) begin
      row_sel_d  = GRID_H'(1) << row_d;
      col_data_d = row_of(disp_d, int'(row_d));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      row_q       <= '0;
      disp_q      <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      row_sel_q   <= '0;
      col_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      disp_q      <= disp_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      row_sel_q   <= row_sel_d;
      col_data_q  <= col_data_d;
    end
  end

  assign grid_ready = ready;
  assign row_sel    = row_sel_q;
  assign col_data   = col_data_q;
  assign frame_done = frame_end;

endmodule

// File: tb/tb_gol_matrix_scan.sv
// Directed bench for gol_matrix_scan with 4-cycle rows and 2-cycle blanking
// (48-cycle frames).
module tb_gol_matrix_scan;

  localparam int RT  = 4;
  localparam int BT  = 2;
  localparam int PER = RT + BT;
  localparam int FRM = 8 * PER;

  typedef logic [7:0][7:0] rows_t;
  typedef struct {
    string       name;
    logic [63:0] grid;
    rows_t       rows;
  } vec_t;

  localparam logic [63:0] G0 = 64'h0412_6424_0034_3C28;
  localparam logic [63:0] GB = 64'h8100_0000_0000_0081;
  localparam logic [63:0] GC = 64'h0102_0408_1020_4080;
  localparam logic [63:0] GF = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [63:0] grid_in;
  logic        grid_valid;
  logic        grid_ready;
  logic [7:0]  row_sel;
  logic [7:0]  col_data;
  logic        frame_done;

  int errors;
  int checks;

  rows_t r_g0, r_b, r_c, r_f, r_z;
  vec_t  vecs[4];

  gol_matrix_scan #(.ROW_TICKS(RT), .BLANK_TICKS(BT)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .grid_in    (grid_in),
    .grid_valid (grid_valid),
    .grid_ready (grid_ready),
    .row_sel    (row_sel),
    .col_data   (col_data),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sample k (1..48) of a frame: blank for the first BT samples of each row slot.
  function automatic logic [7:0] exp_sel(int k);
    logic [7:0] one;
    int p;
    int r;
    one = 8'h01;
    p = (k - 1) % PER;
    r = (k - 1) / PER;
    if (p < BT) return 8'h00;
    return one << r;
  endfunction

  function automatic logic [7:0] exp_col(int k, rows_t rows);
    int p;
    logic [2:0] ri;
    p  = (k - 1) % PER;
    ri = 3'((k - 1) / PER);
    if (p < BT) return 8'h00;
    return rows[ri];
  endfunction

  task automatic check_sample(input int k, input rows_t rows, input string tag);
    chk($sformatf("%s_k%0d_sel", tag, k), {56'h0, row_sel}, {56'h0, exp_sel(k)});
    chk($sformatf("%s_k%0d_col", tag, k), {56'h0, col_data}, {56'h0, exp_col(k, rows)});
    chk($sformatf("%s_k%0d_done", tag, k), {63'h0, frame_done}, {63'h0, (k == FRM)});
  endtask

  // Iteration k drives the edge that produces sample k; mid_ready < 0 skips that check.
  task automatic run_frame(input rows_t rows, input string tag, input int nsamp,
                           input int offer_k, input logic [63:0] offer_grid, input int mid_ready);
    for (int k = 1; k <= nsamp; k++) begin
      if (k == offer_k) begin
        grid_in    = offer_grid;
        grid_valid = 1'b1;
        chk($sformatf("%s_offer_ready", tag), {63'h0, grid_ready}, 64'h1);
      end
      if (k == 24 && mid_ready >= 0)
        chk($sformatf("%s_mid_ready", tag), {63'h0, grid_ready}, 64'(mid_ready));
      tick();
      grid_valid = 1'b0;
      check_sample(k, rows, tag);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_sel"}, {56'h0, row_sel}, 64'h0);
    chk({tag, "_col"}, {56'h0, col_data}, 64'h0);
    chk({tag, "_done"}, {63'h0, frame_done}, 64'h0);
    chk({tag, "_ready"}, {63'h0, grid_ready}, 64'h1);
  endtask

  // Drop to IDLE, hand over a grid there, then leave enable high for the next edge.
  task automatic idle_load(input logic [63:0] g, input string tag);
    enable = 1'b0;
    tick();
    check_idle({tag, "_idle"});
    grid_in    = g;
    grid_valid = 1'b1;
    tick();
    grid_valid = 1'b0;
    enable     = 1'b1;
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    reset      = 1'b1;
    enable     = 1'b1;
    grid_valid = 1'b1;
    grid_in    = G0;

    r_g0 = {8'h28, 8'h3C, 8'h34, 8'h00, 8'h24, 8'h64, 8'h12, 8'h04};
    r_b  = {8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h81};
    r_c  = {8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    r_f  = {8{8'hFF}};
    r_z  = '0;

    vecs[0] = '{name: "g0",    grid: G0, rows: r_g0};
    vecs[1] = '{name: "diag",  grid: 64'h8000_0000_0000_0001,
                rows: {8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80}};
    vecs[2] = '{name: "mix",   grid: 64'hA55A_0FF0_C33C_1248,
                rows: {8'h48, 8'h12, 8'h3C, 8'hC3, 8'hF0, 8'h0F, 8'h5A, 8'hA5}};
    vecs[3] = '{name: "strip", grid: 64'hFF00_FF00_00FF_00FF,
                rows: {8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF}};

    // Reset held with enable and valid high: nothing captured, outputs quiet.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle($sformatf("rst%0d", i));
    end
    reset      = 1'b0;
    grid_valid = 1'b0;
    run_frame(r_z, "post_rst", FRM, 0, '0, 1);

    foreach (vecs[i]) begin
      idle_load(vecs[i].grid, vecs[i].name);
      run_frame(vecs[i].rows, vecs[i].name, FRM, 0, '0, 1);
    end

    // Mid-frame update: all-ones taken during row 2, next grid stalls till frame end.
    idle_load(G0, "mf");
    for (int k = 1; k <= FRM; k++) begin
      if (k == 16) begin
        grid_in    = GF;
        grid_valid = 1'b1;
        chk("mf_first_ready", {63'h0, grid_ready}, 64'h1);
      end else if (k >= 17) begin
        grid_in    = GB;
        grid_valid = 1'b1;
        chk($sformatf("mf_stall_k%0d", k), {63'h0, grid_ready}, 64'h0);
      end
      tick();
      if (k == 16) grid_valid = 1'b0;
      check_sample(k, r_g0, "mf");
    end
    run_frame(r_f, "mf_f2", FRM, 1, GB, 0);
    run_frame(r_b, "mf_f3", FRM, 10, GF, 0);

    // Capture on the frame_end edge while all-ones is pending.
    run_frame(r_f, "sc_f4", FRM, 1, GC, 0);
    run_frame(r_c, "sc_f5", FRM, 0, '0, 1);

    // Enable drop while row 3 drives; re-enable restarts at row 0.
    run_frame(r_c, "ed", 22, 0, '0, -1);
    enable = 1'b0;
    tick();
    check_idle("ed_drop");
    tick();
    check_idle("ed_hold");
    enable = 1'b1;
    run_frame(r_c, "ed_re", FRM, 0, '0, 1);

    // Reset during row 5 clears the displayed grid.
    run_frame(r_c, "rm", 34, 0, '0, -1);
    reset = 1'b1;
    tick();
    check_idle("rm_rst");
    reset = 1'b0;
    run_frame(r_z, "rm_post", FRM, 5, G0, 0);
    run_frame(r_g0, "rm_new", FRM, 0, '0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gol_matrix_scan.md
Name: gol_matrix_scan

Overview:
- Downstream consumer of the gameOfLife generation output (grid_evolve, 8x8 = 64 bits).
- Buffers one offered generation and drives a row-multiplexed 8x8 LED matrix with per-row blanking against ghosting.
- Swaps in new generations only at frame boundaries, so a displayed frame never tears.
- Pending-grid handshake applies back-pressure to the generation stage.

Parameters:
- ROW_TICKS, 1000: clock cycles each row is driven; must be >= 1.
- BLANK_TICKS, 2: clock cycles of all-off blanking before each row; must be >= 1.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  scan enable; low forces blank/idle.
- grid_in  input  64  generation; row r = grid_in[63-8r -: 8], bit 7 of each byte = column 7.
- grid_valid  input  1  grid_in valid this cycle.
- grid_ready  output  1  pending slot can accept; transfer when valid && ready.
- row_sel  output  8  one-hot active-high row drive; row_sel[r] = row r.
- col_data  output  8  column data for the driven row.
- frame_done  output  1  one-cycle pulse on the last DRIVE cycle of row 7.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Storage: disp_buf (64 b), pend_buf (64 b), pend_full flag, row index (3 b), tick counter sized $clog2(max(ROW_TICKS,BLANK_TICKS)).
- Reset: state IDLE, row_sel=0, col_data=0, frame_done=0, disp_buf=0, pend_full=0, so grid_ready=1.
- States:
  - IDLE: outputs zero. If enable=1 at an edge, go to BLANK with row=0 and tick=0.
  - BLANK: row_sel=0, col_data=0 for BLANK_TICKS cycles, then DRIVE.
  - DRIVE: row_sel=1<<row, col_data=disp_buf row slice, for ROW_TICKS cycles.
  - End of DRIVE: if row<7, row+1 and go to BLANK. If row=7, row wraps to 0 and go to BLANK.
- Frame period = 8*(BLANK_TICKS+ROW_TICKS) cycles.
- Output timing: outputs are decoded only from registered state/row/disp_buf and change on the same edge as the state.
- enable=0 in any state: next edge goes to IDLE (outputs zero); row and tick cleared. disp_buf and pend_buf are kept.
- frame_end: combinational, true in DRIVE when row=7 and tick=ROW_TICKS-1. frame_done = frame_end.
- grid_ready = !pend_full || frame_end || (state==IDLE).
- Capture: valid && ready loads pend_buf<=grid_in and sets pend_full.
- Swap at frame_end edge:
  - If pend_full, disp_buf<=pend_buf.
  - pend_full clears unless a capture happens on the same edge, in which case pend_buf takes the new grid and pend_full stays 1.
- IDLE: any pending grid moves to disp_buf on the next edge.
  - A grid captured in IDLE is visible at the first DRIVE after enable.
  - Capture and swap on the same IDLE edge: the old pending grid goes to disp_buf and the new grid stays pending.
- A grid offered while pend_full=0 mid-frame is captured but not shown until the frame_end swap. A later grid offered while full stalls (ready=0).
- Mid-operation reset: same as reset values, taking effect at the next edge.

Decomposition:
- Package gol_pkg:
  - GRID_W=8, GRID_H=8, CELLS=64.
  - typedef logic [CELLS-1:0] grid_t.
  - enum scan_state_t {IDLE, BLANK, DRIVE}.
  - function row_of(grid_t, int r) returning the 8-bit row slice.
- Sub-module gol_row_timer:
  - Parameterised down-counter with load/terminal-count pulse.
  - Reused for the BLANK and DRIVE durations.
- Top module holds the FSM, buffers and handshake.

Test Plan (ROW_TICKS=4, BLANK_TICKS=2, frame=48 cycles; G0=64'h0412_6424_0034_3C28):
- Reset: hold reset 3 cycles with enable=1 and grid_valid=1 → row_sel=0, col_data=0, frame_done=0, grid_ready=1 throughout. First edge after release leaves IDLE.
- Idle load then scan: offer G0 in IDLE (accepted), raise enable at edge t. Required response:
  - t+1..t+2: blank.
  - t+3..t+6: row_sel=8'h01, col_data=8'h04.
  - t+9..t+12: 8'h02/8'h12.
  - Rows continue in order: 8'h64, 8'h24, 8'h00, 8'h34, 8'h3C.
  - Row 7 shows 8'h28 with frame_done high at t+48 only.
- Mid-frame update: during row 2 of G0, offer 64'hFFFF_FFFF_FFFF_FFFF → accepted, pend_full=1.
  - Offer 64'h8100_0000_0000_0081 next: grid_ready=0 until frame_end.
  - Rest of the frame still shows G0; the next frame shows 8'hFF on every row.
- Simultaneous swap and capture: pend_full=1 (all-ones pending); present 64'h0102_0408_1020_4080 with valid exactly on the frame_end cycle. Required response:
  - The handshake completes.
  - Next frame shows 8'hFF on all rows.
  - The following frame shows row0=8'h01 … row7=8'h80.
- Enable drop: drop enable while row 3 is driven → next edge row_sel=0, col_data=0, state IDLE.
  - Re-enable: 2 blank cycles, then row_sel=8'h01 with the disp_buf row-0 value (no resume at row 3).
- Reset mid-scan: assert reset during row 5 → next edge all outputs zero, disp_buf cleared. After release with enable=1, every row shows col_data=8'h00 until a new grid is loaded.
